// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch slice: machine width, reset
// address, instruction size and the word-alignment helper.
package fetch_pkg;

  localparam int unsigned XLEN             = 32;
  localparam int unsigned INSTR_BYTES      = 4;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef logic [XLEN-1:0] addr_t;

  // Instructions are word aligned, so the two low address bits are always zero.
  function automatic addr_t align_word(input addr_t addr);
    return addr & ~addr_t'(3);
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with asynchronous active-low reset to a fixed value.
module pc_reg
  import fetch_pkg::*;
#(
  parameter int unsigned     WIDTH     = XLEN,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pc_d,
  output logic [WIDTH-1:0] pc_q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_VAL;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/fetch.sv
// Instruction fetch PC: sequential increment by PC_STEP, one-cycle branch
// redirect with word-aligned target, branch has priority over increment.
module fetch
  import fetch_pkg::*;
#(
  parameter addr_t       RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned PC_STEP  = INSTR_BYTES
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  branch_taken,
  input  addr_t branch_target,
  output addr_t pc_out,
  output addr_t instr_addr
);

  addr_t pc_d;
  addr_t pc_q;

  // Sequential addition wraps naturally modulo 2^XLEN.
  always_comb begin
    pc_d = pc_q + addr_t'(PC_STEP);
    if (branch_taken) begin
      pc_d = align_word(branch_target);
    end
  end

  pc_reg #(
    .WIDTH    (XLEN),
    .RESET_VAL(align_word(RESET_PC))
  ) u_pc_reg (
    .clk  (clk),
    .rst_n(rst_n),
    .pc_d (pc_d),
    .pc_q (pc_q)
  );

  assign pc_out     = pc_q;
  assign instr_addr = pc_q;

`ifndef SYNTHESIS
  a_outputs_equal : assert property (@(posedge clk) disable iff (!rst_n)
    pc_out == instr_addr);

  a_pc_aligned : assert property (@(posedge clk) disable iff (!rst_n)
    pc_out[1:0] == 2'b00);

  a_legal_update : assert property (@(posedge clk) disable iff (!rst_n)
    1'b1 |=> ($past(branch_taken) ? (pc_q == align_word($past(branch_target)))
                                  : (pc_q == $past(pc_q) + addr_t'(PC_STEP))));
`endif

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: the driver queues the PC expected after each
// edge, a monitor pops and compares on the falling edge or on demand.
module tb_fetch;
  import fetch_pkg::*;

  logic  clk;
  logic  rst_n;
  logic  branch_taken;
  addr_t branch_target;
  addr_t pc_out;
  addr_t instr_addr;

  // Entry layout: {cycle at which the value must be visible, expected pc}.
  logic [63:0] exp_q[$];
  int          cyc;
  int          vectors;
  int          miscompares;
  event        chk_now;

  fetch dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .pc_out       (pc_out),
    .instr_addr   (instr_addr)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  // Monitor / scoreboard.
  initial begin
    logic [63:0] e;
    addr_t       exp_pc;
    forever begin
      @(negedge clk or chk_now);
      while (exp_q.size() > 0 && int'(exp_q[0][63:32]) <= cyc) begin
        e      = exp_q.pop_front();
        exp_pc = e[31:0];
        vectors++;
        if (pc_out !== exp_pc) begin
          miscompares++;
          $display("FAIL pc_out cyc=%0d got=%h expected=%h", cyc, pc_out, exp_pc);
        end
        vectors++;
        if (instr_addr !== exp_pc) begin
          miscompares++;
          $display("FAIL instr_addr cyc=%0d got=%h expected=%h", cyc, instr_addr, exp_pc);
        end
      end
    end
  end

  // Apply inputs for the next rising edge and queue the PC expected after it.
  task automatic drive(input logic rst, input logic bt, input addr_t tgt, input addr_t exp_pc);
    @(negedge clk);
    #1;
    rst_n         = rst;
    branch_taken  = bt;
    branch_target = tgt;
    exp_q.push_back({32'(cyc + 1), exp_pc});
  endtask

  // Assert reset in the low phase with a branch pending; PC must drop at once.
  task automatic async_reset();
    @(negedge clk);
    #3;
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0500;
    rst_n         = 1'b0;
    #1;
    exp_q.push_back({32'(cyc), 32'h0000_0000});
    ->chk_now;
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst_n         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = '0;
    #1;
    exp_q.push_back({32'(cyc), 32'h0000_0000});
    ->chk_now;

    // Reset held over two edges with branch requests that must be ignored.
    drive(1'b0, 1'b1, 32'h0000_0040, 32'h0000_0000);
    drive(1'b0, 1'b1, 32'h0000_0080, 32'h0000_0000);
    drive(1'b1, 1'b0, 32'h0000_0000, 32'h0000_0004);
    drive(1'b1, 1'b0, 32'h0000_0000, 32'h0000_0008);

    // Branch from 8 to 0x20, then resume sequentially.
    drive(1'b1, 1'b1, 32'h0000_0020, 32'h0000_0020);
    drive(1'b1, 1'b0, 32'h0000_0000, 32'h0000_0024);

    // Asynchronous reset while PC=0x24, during a branch request.
    async_reset();
    drive(1'b0, 1'b1, 32'h0000_0500, 32'h0000_0000);
    drive(1'b1, 1'b0, 32'h0000_0000, 32'h0000_0004);
    drive(1'b1, 1'b0, 32'h0000_0000, 32'h0000_0008);

    drive(1'b1, 1'b1, 32'h0000_0020, 32'h0000_0020);
    drive(1'b1, 1'b0, 32'h0000_0000, 32'h0000_0024);
    drive(1'b1, 1'b0, 32'h0000_0000, 32'h0000_0028);

    // Unaligned target is truncated to a word boundary.
    drive(1'b1, 1'b1, 32'h0000_0033, 32'h0000_0030);
    drive(1'b1, 1'b0, 32'h0000_0000, 32'h0000_0034);

    // Wrap-around at the top of the address space.
    drive(1'b1, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    drive(1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000);
    drive(1'b1, 1'b0, 32'h0000_0000, 32'h0000_0004);

    // Back-to-back branches, then sequential.
    drive(1'b1, 1'b1, 32'h0000_0100, 32'h0000_0100);
    drive(1'b1, 1'b1, 32'h0000_0200, 32'h0000_0200);
    drive(1'b1, 1'b1, 32'h0000_0300, 32'h0000_0300);
    drive(1'b1, 1'b0, 32'h0000_0000, 32'h0000_0304);

    // Unaligned wrap target and a further sequential step.
    drive(1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFC);
    drive(1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
